// File: rtl/iter_mult_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : iter_mult_pkg                                                     |
// | Brief  : Shared state encoding and sizing helper for iterative_multiplier. |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

package iter_mult_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/iterative_multiplier_if.sv
// +----------------------------------------------------------------------------+
// | Module : iterative_multiplier_if                                           |
// | Brief  : Request/result bundle between a requester and the multiplier.     |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

interface iterative_multiplier_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               ready;
  logic               done;
  logic [2*WIDTH-1:0] P;

  modport master (
    output start, signed_mode, A, B,
    input  ready, done, P
  );

  modport slave (
    input  start, signed_mode, A, B,
    output ready, done, P
  );
endinterface

`default_nettype wire

// File: rtl/iter_mult_step.sv
// +----------------------------------------------------------------------------+
// | Module : iter_mult_step                                                    |
// | Brief  : One shift-and-add iteration: addend select, extend, add/sub, shift|
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module iter_mult_step
  import iter_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] ra,
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] mq,
  input  logic             smode,
  input  logic             last,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] mq_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   addend_ext;
  logic [WIDTH+1:0] sum;
  logic             new_msb;

  always_comb begin
    addend     = mq[0] ? ra : '0;
    addend_ext = smode ? {addend[WIDTH-1], addend} : {1'b0, addend};
    // The multiplier MSB carries negative weight in two's complement.
    if (smode && last) begin
      sum = {1'b0, acc} - {1'b0, addend_ext};
    end else begin
      sum = {1'b0, acc} + {1'b0, addend_ext};
    end
    new_msb  = smode ? sum[WIDTH] : sum[WIDTH+1];
    acc_next = {new_msb, sum[WIDTH:1]};
    mq_next  = {sum[0], mq[WIDTH-1:1]};
  end

endmodule

`default_nettype wire

// File: rtl/iterative_multiplier.sv
// +----------------------------------------------------------------------------+
// | Module : iterative_multiplier                                              |
// | Brief  : WIDTH x WIDTH -> 2*WIDTH shift-and-add multiplier, signed/unsigned|
// |          Optional macro ITER_MULT_EARLY_TERM_EN: unsigned early finish.    |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module iterative_multiplier
  import iter_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  iterative_multiplier_if.slave  bus
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] mq_q, mq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             smode_q, smode_d;

  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_mq;

  iter_mult_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .ra       (ra_q),
    .acc      (acc_q),
    .mq       (mq_q),
    .smode    (smode_q),
    .last     (cnt_q == CNT_ONE),
    .acc_next (step_acc),
    .mq_next  (step_mq)
  );

`ifdef ITER_MULT_EARLY_TERM_EN
  logic [WIDTH-1:0] pending_mask;
  logic             early_hit;
  logic [2*WIDTH:0] early_shifted;

  // Unprocessed multiplier bits sit in mq_q[cnt_q-1:0]; if all zero the
  // remaining iterations are pure zero-filling shifts.
  always_comb begin
    pending_mask  = ~({WIDTH{1'b1}} << cnt_q);
    early_hit     = !smode_q && (cnt_q > CNT_ONE) && ((mq_q & pending_mask) == '0);
    early_shifted = {acc_q, mq_q} >> cnt_q;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ra_q    <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      cnt_q   <= '0;
      smode_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      cnt_q   <= cnt_d;
      smode_q <= smode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    cnt_d   = cnt_q;
    smode_d = smode_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          ra_d    = bus.A;
          mq_d    = bus.B;
          acc_d   = '0;
          cnt_d   = CNT_INIT;
          smode_d = bus.signed_mode;
          state_d = RUN;
        end
      end

      RUN: begin
`ifdef ITER_MULT_EARLY_TERM_EN
        if (early_hit) begin
          {acc_d, mq_d} = early_shifted;
          cnt_d         = '0;
          state_d       = DONE;
        end else begin
          acc_d = step_acc;
          mq_d  = step_mq;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = DONE;
          end
        end
`else
        acc_d = step_acc;
        mq_d  = step_mq;
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
`endif
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = (state_q == DONE);
  assign bus.P     = {acc_q[WIDTH-1:0], mq_q};

endmodule

`default_nettype wire

// File: tb/tb_iterative_multiplier.sv
// +----------------------------------------------------------------------------+
// | Module : tb_iterative_multiplier                                           |
// | Brief  : Directed self-checking bench for iterative_multiplier, WIDTH=8.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_iterative_multiplier;

  localparam int W = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  iterative_multiplier_if #(.WIDTH(W)) bus ();

  iterative_multiplier #(
    .WIDTH (W)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Issues one request from a negedge; returns the product and the number of
  // clock edges after the accepting edge at which done was first seen.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [2*W-1:0] p, output int lat);
    bus.A = a; bus.B = b; bus.signed_mode = s; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.A = ~a; bus.B = ~b; bus.signed_mode = ~s;
    lat = -1;
    p   = '0;
    for (int k = 1; k <= 4 * W; k++) begin
      @(posedge clock); @(negedge clock);
      if (bus.done === 1'b1) begin
        lat = k;
        p   = bus.P;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.P !== 16'h0000) begin errors++; $display("FAIL reset_P got=%h exp=0000", bus.P); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_unsigned();
    logic [2*W-1:0] p;
    int lat;
    run_op(8'd13, 8'd11, 1'b0, p, lat);
    checks++; if (p !== 16'd143) begin errors++; $display("FAIL u_13x11 got=%0d exp=143", p); end
    checks++; if (lat !== W) begin errors++; $display("FAIL u_latency got=%0d exp=%0d", lat, W); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL ready_in_done got=%b exp=0", bus.ready); end
    @(negedge clock);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got=%b exp=0", bus.done); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL ready_return got=%b exp=1", bus.ready); end
    checks++; if (bus.P !== 16'd143) begin errors++; $display("FAIL p_hold got=%h exp=008f", bus.P); end
    run_op(8'hFF, 8'hFF, 1'b0, p, lat);
    checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL u_ffxff got=%h exp=fe01", p); end
    @(negedge clock);
    run_op(8'h00, 8'hFF, 1'b0, p, lat);
    checks++; if (p !== 16'h0000) begin errors++; $display("FAIL u_00xff got=%h exp=0000", p); end
    @(negedge clock);
  endtask

  task automatic test_signed();
    logic [2*W-1:0] p;
    int lat;
    run_op(8'hFD, 8'h07, 1'b1, p, lat);
    checks++; if (p !== 16'hFFEB) begin errors++; $display("FAIL s_m3x7 got=%h exp=ffeb", p); end
    checks++; if (lat !== W) begin errors++; $display("FAIL s_latency got=%0d exp=%0d", lat, W); end
    @(negedge clock);
    run_op(8'h80, 8'h80, 1'b1, p, lat);
    checks++; if (p !== 16'h4000) begin errors++; $display("FAIL s_m128xm128 got=%h exp=4000", p); end
    @(negedge clock);
    run_op(8'h80, 8'h7F, 1'b1, p, lat);
    checks++; if (p !== 16'hC080) begin errors++; $display("FAIL s_m128x127 got=%h exp=c080", p); end
    @(negedge clock);
    run_op(8'hFF, 8'h01, 1'b1, p, lat);
    checks++; if (p !== 16'hFFFF) begin errors++; $display("FAIL s_m1x1 got=%h exp=ffff", p); end
    checks++; if (lat !== W) begin errors++; $display("FAIL s_m1x1_latency got=%0d exp=%0d", lat, W); end
    @(negedge clock);
  endtask

  task automatic test_ignore_start();
    int dones = 0;
    int first = -1;
    logic [2*W-1:0] p = '0;
    bus.A = 8'd13; bus.B = 8'd11; bus.signed_mode = 1'b0; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 2 * W + 4; k++) begin
      if (k == 3) begin
        bus.A = 8'd5; bus.B = 8'd5; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clock); @(negedge clock);
      if (bus.done === 1'b1) begin
        dones++;
        if (first < 0) begin first = k; p = bus.P; end
      end
    end
    bus.start = 1'b0;
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    checks++; if (p !== 16'd143) begin errors++; $display("FAIL ignore_result got=%0d exp=143", p); end
    checks++; if (first !== W) begin errors++; $display("FAIL ignore_latency got=%0d exp=%0d", first, W); end
    checks++; if (bus.P !== 16'd143) begin errors++; $display("FAIL ignore_hold got=%0d exp=143", bus.P); end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int last  = -1;
    bus.A = 8'd7; bus.B = 8'd9; bus.signed_mode = 1'b0; bus.start = 1'b1;
    for (int k = 1; k <= 5 * (W + 2); k++) begin
      @(posedge clock); @(negedge clock);
      if (bus.done === 1'b1) begin
        dones++;
        checks++; if (bus.P !== 16'd63) begin errors++; $display("FAIL b2b_result got=%0d exp=63", bus.P); end
        if (last >= 0) begin
          checks++; if (k - last !== W + 2) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", k - last, W + 2); end
        end
        last = k;
        if (dones == 3) begin
          bus.start = 1'b0;
          break;
        end
      end
    end
    bus.start = 1'b0;
    checks++; if (dones !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", dones); end
    @(negedge clock);
    @(negedge clock);
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got=%b exp=1", bus.ready); end
  endtask

  task automatic test_async_reset();
    logic [2*W-1:0] p;
    int lat;
    bus.A = 8'd200; bus.B = 8'd3; bus.signed_mode = 1'b0; bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL areset_ready got=%b exp=1", bus.ready); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL areset_done got=%b exp=0", bus.done); end
    checks++; if (bus.P !== 16'h0000) begin errors++; $display("FAIL areset_P got=%h exp=0000", bus.P); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run_op(8'd5, 8'd6, 1'b0, p, lat);
    checks++; if (p !== 16'd30) begin errors++; $display("FAIL areset_after got=%0d exp=30", p); end
    @(negedge clock);
  endtask

`ifdef ITER_MULT_EARLY_TERM_EN
  task automatic test_early_term();
    logic [2*W-1:0] p;
    int lat;
    run_op(8'd200, 8'd3, 1'b0, p, lat);
    checks++; if (p !== 16'd600) begin errors++; $display("FAIL et_200x3 got=%0d exp=600", p); end
    checks++; if (lat >= W) begin errors++; $display("FAIL et_short got=%0d exp<%0d", lat, W); end
    @(negedge clock);
    run_op(8'd77, 8'd0, 1'b0, p, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL et_b0_latency got=%0d exp=1", lat); end
    checks++; if (p !== 16'd0) begin errors++; $display("FAIL et_b0 got=%0d exp=0", p); end
    @(negedge clock);
  endtask
`endif

  task automatic test_random();
    logic [2*W-1:0] p;
    logic [2*W-1:0] exp_p;
    logic [W-1:0]   a, b;
    logic           s;
    int             lat, ia, ib;
    for (int n = 0; n < 300; n++) begin
      a = W'($urandom);
      b = W'($urandom);
      s = 1'($urandom);
      ia = s ? int'($signed(a)) : int'(a);
      ib = s ? int'($signed(b)) : int'(b);
      exp_p = (2 * W)'(ia * ib);
      run_op(a, b, s, p, lat);
      checks++; if (p !== exp_p) begin errors++; $display("FAIL rand_product a=%h b=%h s=%b got=%h exp=%h", a, b, s, p, exp_p); end
`ifdef ITER_MULT_EARLY_TERM_EN
      checks++; if (lat < 1 || lat > W) begin errors++; $display("FAIL rand_latency got=%0d exp=1..%0d", lat, W); end
`else
      checks++; if (lat !== W) begin errors++; $display("FAIL rand_latency got=%0d exp=%0d", lat, W); end
`endif
      @(negedge clock);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.signed_mode = 1'b0;
    bus.A = '0;
    bus.B = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
`ifdef ITER_MULT_EARLY_TERM_EN
    test_early_term();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
